// File: rtl/eu_operand_collector.sv
// eu_operand_collector: gathers both source operands for one instruction from the
// register file, the forwarding bus or the immediate, then holds it until the ALU takes it.
module eu_operand_collector #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OPC_W      = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [OPC_W-1:0]      instr_opcode_i,
    input  logic [REG_ADDR_W-1:0] instr_rd_i,
    input  logic [REG_ADDR_W-1:0] instr_rs1_i,
    input  logic [REG_ADDR_W-1:0] instr_rs2_i,
    input  logic [DATA_W-1:0]     instr_imm_i,
    input  logic                  instr_use_imm_i,
    output logic [REG_ADDR_W-1:0] rf_raddr0_o,
    output logic [REG_ADDR_W-1:0] rf_raddr1_o,
    input  logic [DATA_W-1:0]     rf_rdata0_i,
    input  logic [DATA_W-1:0]     rf_rdata1_i,
    input  logic                  rf_busy0_i,
    input  logic                  rf_busy1_i,
    input  logic                  fwd_valid_i,
    input  logic [REG_ADDR_W-1:0] fwd_addr_i,
    input  logic [DATA_W-1:0]     fwd_data_i,
    output logic                  issue_valid_o,
    input  logic                  issue_ready_i,
    output logic [OPC_W-1:0]      issue_opcode_o,
    output logic [REG_ADDR_W-1:0] issue_rd_o,
    output logic [DATA_W-1:0]     issue_op_a_o,
    output logic [DATA_W-1:0]     issue_op_b_o
);
    typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_e;

    state_e                state_q;
    logic [OPC_W-1:0]      opcode_q;
    logic [REG_ADDR_W-1:0] rd_q, rs1_q, rs2_q;
    logic [DATA_W-1:0]     a_q, b_q;
    logic                  a_ok_q, b_ok_q;
    logic                  accept, fwd_a, fwd_b, take_a, take_b;

    assign instr_ready_o  = (state_q == IDLE) || (state_q == ISSUE && issue_ready_i);
    assign accept         = instr_valid_i && instr_ready_o;
    assign fwd_a          = fwd_valid_i && (fwd_addr_i == rs1_q);
    assign fwd_b          = fwd_valid_i && (fwd_addr_i == rs2_q);
    assign take_a         = !a_ok_q && (fwd_a || !rf_busy0_i);
    assign take_b         = !b_ok_q && (fwd_b || !rf_busy1_i);
    assign rf_raddr0_o    = rs1_q;
    assign rf_raddr1_o    = rs2_q;
    assign issue_valid_o  = (state_q == ISSUE);
    assign issue_opcode_o = opcode_q;
    assign issue_rd_o     = rd_q;
    assign issue_op_a_o   = a_q;
    assign issue_op_b_o   = b_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_ok_q   <= 1'b0;
            b_ok_q   <= 1'b0;
        end else if (accept) begin
            // r0 and immediates need no collection; bus traffic this cycle is ignored
            state_q  <= COLLECT;
            opcode_q <= instr_opcode_i;
            rd_q     <= instr_rd_i;
            rs1_q    <= instr_rs1_i;
            rs2_q    <= instr_rs2_i;
            a_q      <= '0;
            b_q      <= instr_use_imm_i ? instr_imm_i : '0;
            a_ok_q   <= (instr_rs1_i == '0);
            b_ok_q   <= instr_use_imm_i || (instr_rs2_i == '0);
        end else begin
            case (state_q)
                COLLECT: begin
                    if (take_a) begin
                        a_q    <= fwd_a ? fwd_data_i : rf_rdata0_i;
                        a_ok_q <= 1'b1;
                    end
                    if (take_b) begin
                        b_q    <= fwd_b ? fwd_data_i : rf_rdata1_i;
                        b_ok_q <= 1'b1;
                    end
                    if ((a_ok_q || take_a) && (b_ok_q || take_b))
                        state_q <= ISSUE;
                end
                ISSUE:   if (issue_ready_i) state_q <= IDLE;
                default: ;
            endcase
        end
    end
endmodule
